// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types and default widths for the i2c transaction arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_arb_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DATAWIDTH      = 8;
  localparam int DEF_ADDRWIDTH      = 6;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and i2c-controller-side signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid is held until req_ready; the controller side has none.
// Modports: slave = arbiter view, master = requesters + i2c controller view.
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_wr;
  logic [NUM_REQ*ADDRWIDTH-1:0] req_addr;
  logic [NUM_REQ*DATAWIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DATAWIDTH-1:0]         rsp_rdata;
  logic                         rsp_err;
  logic                         i2c_wr_en;
  logic                         i2c_rd_en;
  logic [ADDRWIDTH-1:0]         i2c_addr;
  logic [DATAWIDTH-1:0]         i2c_wdata;
  logic                         i2c_done;
  logic [DATAWIDTH-1:0]         i2c_rdata;
  logic                         busy;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, i2c_done, i2c_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           i2c_wr_en, i2c_rd_en, i2c_addr, i2c_wdata, busy
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, i2c_done, i2c_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           i2c_wr_en, i2c_rd_en, i2c_addr, i2c_wdata, busy
  );

endinterface

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after the pointer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant follows i_valid within the same cycle.
// Ports: i_valid (request vector), i_ptr (last winner), o_grant (one-hot),
//        o_idx (winner index), o_any (some requester is valid).
module i2c_rr_pick #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int pos;

  // Search starts one past the last winner and wraps, so the last winner
  // is considered last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    pos     = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(i_ptr) + k) % N;
      if (!o_any && i_valid[PW'(pos)]) begin
        o_any            = 1'b1;
        o_grant[PW'(pos)] = 1'b1;
        o_idx            = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c controller among NUM_REQ requesters.
// Latency: strobe one cycle after accept; response one cycle after i2c_done.
// Backpressure: req_ready only in IDLE; a single transaction outstanding at a time.
// Ports: clk, reset (async, active-high), bus (slave modport of i2c_txn_arbiter_if).
// Optional: define I2C_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT_CYCLES and flag rsp_err.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int ADDRWIDTH      = DEF_ADDRWIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic            clk,
  input logic            reset,
  i2c_txn_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_txn_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_owner;
  logic                 r_wr;
  logic [ADDRWIDTH-1:0] r_addr;
  logic [DATAWIDTH-1:0] r_wdata;
  logic                 r_wr_en;
  logic                 r_rd_en;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATAWIDTH-1:0] r_rsp_rdata;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_grant;
  logic [PW-1:0]        w_idx;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_expire;

  i2c_rr_pick #(.N(NUM_REQ)) u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The grant is a subset of req_valid, so any grant in IDLE is a handshake.
  assign w_accept      = (r_state == IDLE) && w_any;
  assign w_done        = (r_state == WAIT) && bus.i2c_done;
  assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_rsp_err;

  // r_to_cnt holds the number of WAIT cycles already completed, so the
  // TIMEOUT_CYCLES-th WAIT cycle is the one that expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_expire = (r_state == WAIT) && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // A done arriving on the expiry cycle takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_expire && !bus.i2c_done;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_expire    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (bus.i2c_done || w_expire) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= PW'(NUM_REQ - 1);
      r_owner     <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      // Strobes and response fields are single-cycle by default.
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_busy      <= (w_next != IDLE);

      if (w_accept) begin
        r_owner  <= w_idx;
        r_rr_ptr <= w_idx;
        r_wr     <= bus.req_wr[w_idx];
        r_addr   <= bus.req_addr[w_idx*ADDRWIDTH +: ADDRWIDTH];
        r_wdata  <= bus.req_wdata[w_idx*DATAWIDTH +: DATAWIDTH];
        // Registered here so the strobe lands in the ISSUE cycle.
        r_wr_en  <= bus.req_wr[w_idx];
        r_rd_en  <= ~bus.req_wr[w_idx];
      end

      if (w_done) begin
        r_rsp_valid <= NUM_REQ'(1) << r_owner;
        r_rsp_rdata <= r_wr ? '0 : bus.i2c_rdata;
      end else if (w_expire) begin
        r_rsp_valid <= NUM_REQ'(1) << r_owner;
      end
    end
  end

  assign bus.i2c_wr_en = r_wr_en;
  assign bus.i2c_rd_en = r_rd_en;
  assign bus.i2c_addr  = r_addr;
  assign bus.i2c_wdata = r_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: strobes and responses checked against queues.
// Latency: n/a.
// Backpressure: requesters hold req_valid until accepted.
module tb_i2c_txn_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 6;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } strb_t;

  typedef struct {
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NUM_REQ(NR), .DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  i2c_txn_arbiter #(
    .NUM_REQ(NR), .DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int      n_cmp = 0;
  int      n_err = 0;
  strb_t   strb_q[$];
  resp_t   resp_q[$];
  int      cyc = 0;
  int      acc_cyc = -100;
  int      done_cyc = -100;
  logic [NR-1:0] pend_acc = '0;
  bit      hold_all = 1'b0;
  bit      ctl_auto = 1'b1;
  int      ctl_delay = 3;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: drop req_valid once the handshake edge has passed.
  always @(negedge clk) begin
    if (!hold_all) bus.req_valid = bus.req_valid & ~pend_acc;
    pend_acc = bus.req_valid & bus.req_ready;
    if (pend_acc != '0) acc_cyc = cyc;
  end

  // Controller model: answer each strobe ctl_delay cycles later.
  always @(negedge clk) begin
    if (ctl_auto && !reset && (bus.i2c_wr_en || bus.i2c_rd_en)) begin
      logic [AW-1:0] a;
      logic          w;
      a = bus.i2c_addr;
      w = bus.i2c_wr_en;
      repeat (ctl_delay) @(negedge clk);
      bus.i2c_rdata = w ? 8'hEE : (DW'(a) ^ 8'h63);
      bus.i2c_done  = 1'b1;
      done_cyc      = cyc;
      @(negedge clk);
      bus.i2c_done  = 1'b0;
      bus.i2c_rdata = '0;
    end
  end

  // Monitor: compare strobes and responses with the scoreboard queues.
  always @(negedge clk) begin
    strb_t s;
    resp_t r;
    if (!reset) begin
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      if (bus.busy) chk("ready_busy", 32'(bus.req_ready), 0);
      if (bus.i2c_wr_en || bus.i2c_rd_en) begin
        if (strb_q.size() == 0) chk("strb_unexp", 1, 0);
        else begin
          s = strb_q.pop_front();
          chk("strb_kind", {bus.i2c_wr_en, bus.i2c_rd_en}, {s.wr, ~s.wr});
          chk("strb_addr", 32'(bus.i2c_addr), 32'(s.addr));
          chk("strb_wdata", 32'(bus.i2c_wdata), 32'(s.wdata));
          chk("strb_lat", cyc, acc_cyc + 1);
          last_addr = s.addr;
        end
      end
      if (bus.rsp_valid != '0) begin
        if (resp_q.size() == 0) chk("rsp_unexp", 1, 0);
        else begin
          r = resp_q.pop_front();
          chk("rsp_owner", 32'(bus.rsp_valid), 32'(1) << r.owner);
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
          chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          chk("rsp_lat", cyc, done_cyc + 1);
          chk("addr_hold", 32'(bus.i2c_addr), 32'(last_addr));
        end
      end else begin
        chk("rsp_idle_zero", {bus.rsp_err, bus.rsp_rdata}, 0);
      end
    end
  end

  task automatic push_exp(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    strb_t s;
    resp_t r;
    s.wr = wr; s.addr = a; s.wdata = d;
    strb_q.push_back(s);
    r.owner = i;
    r.rdata = wr ? '0 : (DW'(a) ^ 8'h63);
    r.err   = 1'b0;
    resp_q.push_back(r);
  endtask

  task automatic drive(input int i, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit push);
    bus.req_wr[i]            = wr;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_valid[i]         = 1'b1;
    if (push) push_exp(i, wr, a, d);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!bus.busy && bus.req_valid == '0 && resp_q.size() == 0) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_strobe();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.i2c_wr_en || bus.i2c_rd_en) return;
    end
    chk("strobe_timeout", 1, 0);
  endtask

  initial begin
    int ord[6];
    int seen;
    int g;
    ord = '{0, 1, 2, 3, 0, 1};
    bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.i2c_done = 1'b0; bus.i2c_rdata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_strobes", {bus.i2c_wr_en, bus.i2c_rd_en}, 0);
    chk("rst_addr", 32'(bus.i2c_addr), 0);
    chk("rst_wdata", 32'(bus.i2c_wdata), 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
    reset = 1'b0;

    // Fairness: all requesters held valid from reset; rotation starts at 0.
    ctl_delay = 1;
    hold_all  = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) drive(i, i[0], AW'(16 + i), DW'(48 + i), 1'b0);
    for (int k = 0; k < 6; k++) begin
      g = ord[k];
      push_exp(g, g[0], AW'(16 + g), DW'(48 + g));
    end
    seen = 0;
    for (int t = 0; t < 200 && seen < 6; t++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen++;
    end
    chk("fair_rsps", seen, 6);
    @(posedge clk); #1;
    bus.req_valid = '0;
    hold_all = 1'b0;
    wait_idle();

    // Single write, done three cycles after the strobe.
    ctl_delay = 3;
    @(posedge clk); #1;
    drive(0, 1'b1, 6'h05, 8'hA5, 1'b1);
    wait_idle();

    // Single read from requester 2: 0x3F ^ 0x63 = 0x5C.
    @(posedge clk); #1;
    drive(2, 1'b0, 6'h3F, 8'h11, 1'b1);
    wait_idle();

    // Spurious done in IDLE and in ISSUE.
    ctl_auto = 1'b0;
    @(negedge clk); bus.i2c_done = 1'b1;
    @(negedge clk); bus.i2c_done = 1'b0;
    chk("spur_idle_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    drive(3, 1'b0, 6'h2A, 8'h00, 1'b1);
    wait_strobe();
    bus.i2c_rdata = 8'hFF; bus.i2c_done = 1'b1;
    @(negedge clk); bus.i2c_done = 1'b0; bus.i2c_rdata = '0;
    repeat (2) @(negedge clk);
    chk("spur_issue_busy", 32'(bus.busy), 1);
    bus.i2c_rdata = 8'h49; bus.i2c_done = 1'b1; done_cyc = cyc;
    @(negedge clk); bus.i2c_done = 1'b0; bus.i2c_rdata = '0;
    wait_idle();

    // Reset while waiting for the controller: no response, pointer restarts.
    @(posedge clk); #1;
    drive(1, 1'b1, 6'h22, 8'h44, 1'b1);
    wait_strobe();
    repeat (2) @(negedge clk);
    void'(resp_q.pop_back());
    reset = 1'b1;
    #1;
    chk("rstw_busy", 32'(bus.busy), 0);
    chk("rstw_strobes", {bus.i2c_wr_en, bus.i2c_rd_en}, 0);
    chk("rstw_addr", 32'(bus.i2c_addr), 0);
    chk("rstw_wdata", 32'(bus.i2c_wdata), 0);
    chk("rstw_rsp", 32'(bus.rsp_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ctl_auto  = 1'b1;
    ctl_delay = 2;
    @(posedge clk); #1;
    drive(0, 1'b0, 6'h01, 8'h00, 1'b1);
    drive(3, 1'b1, 6'h33, 8'h77, 1'b1);
    wait_idle();

`ifdef I2C_ARB_TIMEOUT_EN
    // No done: error response after TO WAIT cycles.
    ctl_auto = 1'b0;
    @(posedge clk); #1;
    drive(2, 1'b1, 6'h0C, 8'h5A, 1'b1);
    resp_q[resp_q.size()-1].err   = 1'b1;
    resp_q[resp_q.size()-1].rdata = '0;
    wait_strobe();
    done_cyc = cyc + TO;
    wait_idle();
    ctl_auto = 1'b1;
`endif

    repeat (3) @(negedge clk);
    chk("strb_q_left", strb_q.size(), 0);
    chk("resp_q_left", resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
